// File: rtl/router_fsm_np.sv
// Router control FSM for NUM_PORTS output FIFOs: header decode, header/payload/parity
// load sequencing, full-FIFO stall, illegal-address drop, bounded wait-for-empty
// and per-port soft reset of the selected channel.
module router_fsm_np #(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W        = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_rst,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 full_state,
  output logic                 laf_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic                 drop_state,
  output logic [ADDR_W-1:0]    dest_sel,
  output logic                 timeout_err
);

  typedef enum logic [3:0] {
    S_DA, S_LFD, S_LD, S_FULL, S_LAF, S_LP, S_CPE, S_WTE, S_DROP
  } state_t;

  localparam int SEL_N = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  NUM_PORTS_W = (ADDR_W + 1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dest_sel_q, dest_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  // Per-port flags widened to the full address space so any address indexes safely;
  // addresses with no FIFO read as "not empty" and "no soft reset".
  logic [SEL_N-1:0] empty_ext;
  logic [SEL_N-1:0] srst_ext;

  genvar gi;
  generate
    for (gi = 0; gi < SEL_N; gi++) begin : g_ext
      if (gi < NUM_PORTS) begin : g_real
        assign empty_ext[gi] = fifo_empty[gi];
        assign srst_ext[gi]  = soft_rst[gi];
      end else begin : g_pad
        assign empty_ext[gi] = 1'b0;
        assign srst_ext[gi]  = 1'b0;
      end
    end
  endgenerate

  logic addr_legal;
  assign addr_legal = ({1'b0, data_in} < NUM_PORTS_W);

  // State, latched destination, wait counter and timeout pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_DA;
      dest_sel_q <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_sel_q <= dest_sel_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic; soft reset of the selected port overrides every transition.
  always_comb begin
    state_d    = state_q;
    dest_sel_d = dest_sel_q;
    cnt_d      = '0;
    timeout_d  = 1'b0;
    if (state_q == S_WTE) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      S_DA: begin
        if (pkt_valid) begin
          dest_sel_d = data_in;
          if (!addr_legal)             state_d = S_DROP;
          else if (empty_ext[data_in]) state_d = S_LFD;
          else                         state_d = S_WTE;
        end
      end
      S_LFD:  state_d = S_LD;
      S_LD: begin
        if (fifo_full)       state_d = S_FULL;
        else if (!pkt_valid) state_d = S_LP;
      end
      S_FULL: if (!fifo_full) state_d = S_LAF;
      S_LAF: begin
        if (parity_done)        state_d = S_DA;
        else if (low_pkt_valid) state_d = S_LP;
        else                    state_d = S_LD;
      end
      S_LP:   state_d = S_CPE;
      S_CPE:  state_d = fifo_full ? S_FULL : S_DA;
      S_WTE: begin
        // An empty FIFO on the final wait cycle still wins over the timeout.
        if (empty_ext[dest_sel_q]) begin
          state_d = S_LFD;
        end else if ((WAIT_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d   = S_DROP;
          timeout_d = 1'b1;
        end
      end
      S_DROP: if (!pkt_valid) state_d = S_DA;
      default: state_d = S_DA;
    endcase
    if ((state_q != S_DA) && (state_q != S_DROP) && srst_ext[dest_sel_q]) begin
      state_d   = S_DA;
      timeout_d = 1'b0;
    end
  end

  // Moore output decode of the state register.
  always_comb begin
    busy          = 1'b0;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    full_state    = 1'b0;
    laf_state     = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    drop_state    = 1'b0;
    case (state_q)
      S_DA:   detect_add = 1'b1;
      S_LFD:  begin busy = 1'b1; lfd_state = 1'b1; end
      S_LD:   begin ld_state = 1'b1; write_enb_reg = 1'b1; end
      S_FULL: begin busy = 1'b1; full_state = 1'b1; end
      S_LAF:  begin busy = 1'b1; laf_state = 1'b1; write_enb_reg = 1'b1; end
      S_LP:   begin busy = 1'b1; write_enb_reg = 1'b1; end
      S_CPE:  begin busy = 1'b1; rst_int_reg = 1'b1; end
      S_WTE:  busy = 1'b1;
      S_DROP: drop_state = 1'b1;
      default: detect_add = 1'b1;
    endcase
  end

  assign dest_sel    = dest_sel_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np: a 4-port build and a 3-port build (for the
// illegal-address case), both with an 8-cycle wait timeout.
module tb_router_fsm_np;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic [3:0] fifo_empty, soft_rst;

  logic       busy_a, det_a, lfd_a, ld_a, full_a, laf_a, wenb_a, rint_a, drop_a, tmo_a;
  logic [1:0] dsel_a;
  logic       busy_b, det_b, lfd_b, ld_b, full_b, laf_b, wenb_b, rint_b, drop_b, tmo_b;
  logic [1:0] dsel_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  router_fsm_np #(.NUM_PORTS(4), .ADDR_W(2), .WAIT_TIMEOUT(8), .CNT_W(7)) dut_a (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_rst(soft_rst),
    .busy(busy_a), .detect_add(det_a), .lfd_state(lfd_a), .ld_state(ld_a),
    .full_state(full_a), .laf_state(laf_a), .write_enb_reg(wenb_a),
    .rst_int_reg(rint_a), .drop_state(drop_a), .dest_sel(dsel_a), .timeout_err(tmo_a)
  );

  router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(8), .CNT_W(7)) dut_b (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty[2:0]), .soft_rst(soft_rst[2:0]),
    .busy(busy_b), .detect_add(det_b), .lfd_state(lfd_b), .ld_state(ld_b),
    .full_state(full_b), .laf_state(laf_b), .write_enb_reg(wenb_b),
    .rst_int_reg(rint_b), .drop_state(drop_b), .dest_sel(dsel_b), .timeout_err(tmo_b)
  );

  // Output bundle: {busy, detect_add, lfd, ld, full, laf, write_enb, rst_int, drop, timeout_err}
  logic [9:0] outs_a, outs_b;
  assign outs_a = {busy_a, det_a, lfd_a, ld_a, full_a, laf_a, wenb_a, rint_a, drop_a, tmo_a};
  assign outs_b = {busy_b, det_b, lfd_b, ld_b, full_b, laf_b, wenb_b, rint_b, drop_b, tmo_b};

  localparam logic [9:0] E_DA   = 10'b0100000000;
  localparam logic [9:0] E_LFD  = 10'b1010000000;
  localparam logic [9:0] E_LD   = 10'b0001001000;
  localparam logic [9:0] E_FULL = 10'b1000100000;
  localparam logic [9:0] E_LAF  = 10'b1000011000;
  localparam logic [9:0] E_LP   = 10'b1000001000;
  localparam logic [9:0] E_CPE  = 10'b1000000100;
  localparam logic [9:0] E_WTE  = 10'b1000000000;
  localparam logic [9:0] E_DROP = 10'b0000000010;
  localparam logic [9:0] E_TMO  = 10'b0000000001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    fifo_full = 1'b0; fifo_empty = 4'b0000; soft_rst = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values.
    do_reset();
    check("reset_outs_a", outs_a, E_DA);
    check("reset_dsel_a", dsel_a, 0);
    check("reset_outs_b", outs_b, E_DA);

    // 1: basic packet to port 1.
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 4'b0010;
    step(); check("t1_lfd", outs_a, E_LFD);
    step(); check("t1_ld0", outs_a, E_LD);
    step(); check("t1_ld1", outs_a, E_LD);
    pkt_valid = 1'b0;
    step(); check("t1_lp", outs_a, E_LP);
    step(); check("t1_cpe", outs_a, E_CPE);
    step(); check("t1_da", outs_a, E_DA);
    check("t1_dsel", dsel_a, 1);
    $display("test 1 basic packet done");

    // 2: full stall on port 3, then asynchronous reset mid-packet.
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd3; fifo_empty = 4'b1000;
    step(); check("t2_lfd", outs_a, E_LFD);
    step(); check("t2_ld", outs_a, E_LD);
    fifo_full = 1'b1;
    step(); check("t2_full0", outs_a, E_FULL);
    step(); check("t2_full1", outs_a, E_FULL);
    fifo_full = 1'b0;
    step(); check("t2_laf", outs_a, E_LAF);
    step(); check("t2_ld_again", outs_a, E_LD);
    check("t2_dsel", dsel_a, 3);
    #2 rst = 1'b1;
    #1 check("t2_async_rst_outs", outs_a, E_DA);
    check("t2_async_rst_dsel", dsel_a, 0);
    $display("test 2 full stall done");

    // 3: illegal address on the 3-port build.
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd3;
    step(); check("t3_drop0", outs_b, E_DROP);
    step(); check("t3_drop1", outs_b, E_DROP);
    check("t3_dsel", dsel_b, 3);
    pkt_valid = 1'b0;
    step(); check("t3_da", outs_b, E_DA);
    $display("test 3 illegal address done");

    // 4: wait-for-empty timeout on port 2.
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step(); check($sformatf("t4_wte%0d", i), outs_a, E_WTE);
    end
    step(); check("t4_drop_tmo", outs_a, E_DROP | E_TMO);
    step(); check("t4_drop_no_tmo", outs_a, E_DROP);
    pkt_valid = 1'b0;
    step(); check("t4_da", outs_a, E_DA);
    $display("test 4 wait timeout done");

    // 5: FIFO empties on the final wait cycle.
    do_reset();
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step(); check($sformatf("t5_wte%0d", i), outs_a, E_WTE);
    end
    fifo_empty = 4'b0100;
    step(); check("t5_lfd_no_tmo", outs_a, E_LFD);
    step(); check("t5_ld", outs_a, E_LD);
    $display("test 5 empty beats timeout done");

    // 6: soft reset on unselected then selected port.
    do_reset();
    soft_rst = 4'b0010;
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 4'b0010;
    step(); check("t6_da_ignores_srst", outs_a, E_LFD);
    soft_rst = 4'b0000;
    step(); check("t6_ld", outs_a, E_LD);
    soft_rst = 4'b0100;
    step(); check("t6_other_port", outs_a, E_LD);
    soft_rst = 4'b0010;
    step(); check("t6_srst_da", outs_a, E_DA);
    check("t6_detect_add", det_a, 1);
    soft_rst = 4'b0000;
    $display("test 6 soft reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
